// File: rtl/normalize_round.sv
//------------------------------------------------------------------------------
// normalize_round : FP add/sub back end - normalize, round (RNE), pack, flags
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sign,
  input  logic [EXP_W-1:0]        i_exp,
  input  logic [FRAC_W+4:0]       i_mant,
  input  logic [7:0]              i_lzc,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [EXP_W+FRAC_W:0]   o_result,
  output logic                    o_zero,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_inexact
);

  localparam int MANT_W = FRAC_W + 5;
  localparam int EW     = EXP_W + 2;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam int RES_W  = EXP_W + FRAC_W + 1;

  // Handshake
  logic s1_v_q, out_v_q;
  logic s1_en, s2_en;

  assign s2_en   = !out_v_q || i_ready;
  assign s1_en   = !s1_v_q || s2_en;
  assign o_ready = s1_en;
  assign o_valid = out_v_q;

  // Stage 1: normalize
  logic [7:0]        shamt;
  logic [MANT_W-2:0] s1_m_d, s1_m_q;
  logic [EW-1:0]     s1_e_d, s1_e_q;
  logic              s1_zero_d, s1_zero_q;
  logic              s1_uf_d, s1_uf_q;
  logic              s1_sign_q;

  assign shamt = i_lzc - 8'd1;

  // Bit MANT_W-1 is always clear after normalization, so it is not stored.
  always_comb begin
    s1_zero_d = (i_mant == '0);
    if (i_lzc == 8'd0) begin
      s1_m_d = {i_mant[MANT_W-1:2], |i_mant[1:0]};
      s1_e_d = {2'b00, i_exp} + EW'(1);
    end else begin
      s1_m_d = (MANT_W-1)'(i_mant << shamt);
      s1_e_d = {2'b00, i_exp} - EW'(shamt);
    end
    s1_uf_d = !s1_zero_d && (s1_e_d[EW-1] || (s1_e_d == '0));
  end

  // Stage 2: round to nearest even and pack
  logic              lsb, g, rs, up, carry;
  logic [FRAC_W+1:0] r;
  logic [FRAC_W-1:0] frac;
  logic [EW-1:0]     e2;
  logic              ovf;
  logic [RES_W-1:0]  res_d;
  logic              zero_d, ovf_d, uf_d, inx_d;

  always_comb begin
    lsb   = s1_m_q[3];
    g     = s1_m_q[2];
    rs    = |s1_m_q[1:0];
    up    = g && (rs || lsb);
    r     = {1'b0, s1_m_q[MANT_W-2:3]} + (FRAC_W+2)'(up);
    carry = r[FRAC_W+1];
    frac  = carry ? r[FRAC_W:1] : r[FRAC_W-1:0];
    e2    = s1_e_q + EW'(carry);
    ovf   = !e2[EW-1] && (e2 >= EW'(EMAX));

    res_d  = '0;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    uf_d   = 1'b0;
    inx_d  = 1'b0;
    if (s1_zero_q) begin
      res_d  = {s1_sign_q, {(RES_W-1){1'b0}}};
      zero_d = 1'b1;
    end else if (s1_uf_q) begin
      res_d = {s1_sign_q, {(RES_W-1){1'b0}}};
      uf_d  = 1'b1;
      inx_d = 1'b1;
    end else if (ovf) begin
      res_d = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      res_d = {s1_sign_q, e2[EXP_W-1:0], frac};
      inx_d = g || rs;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_m_q      <= '0;
      s1_e_q      <= '0;
      s1_zero_q   <= 1'b0;
      s1_uf_q     <= 1'b0;
      out_v_q     <= 1'b0;
      o_result    <= '0;
      o_zero      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v_q <= i_valid;
        if (i_valid) begin
          s1_sign_q <= i_sign;
          s1_m_q    <= s1_m_d;
          s1_e_q    <= s1_e_d;
          s1_zero_q <= s1_zero_d;
          s1_uf_q   <= s1_uf_d;
        end
      end
      // Outputs only update on a stage-2 load, so they hold under backpressure.
      if (s2_en) begin
        out_v_q <= s1_v_q;
        if (s1_v_q) begin
          o_result    <= res_d;
          o_zero      <= zero_d;
          o_overflow  <= ovf_d;
          o_underflow <= uf_d;
          o_inexact   <= inx_d;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_normalize_round.sv
//------------------------------------------------------------------------------
// tb_normalize_round : vector table + scoreboard bench for normalize_round
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid, o_ready, i_sign, o_valid, i_ready;
  logic [7:0]  i_exp, i_lzc;
  logic [27:0] i_mant;
  logic [31:0] o_result;
  logic        o_zero, o_overflow, o_underflow, o_inexact;

  always #5 clk = ~clk;

  normalize_round dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_mant(i_mant), .i_lzc(i_lzc),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_inexact(o_inexact)
  );

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [7:0]  lzc;
    logic [31:0] res;
    logic [3:0]  fl;   // {zero, overflow, underflow, inexact}
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
    logic [7:0]  id;
  } exp_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  exp_t sbq [$];
  exp_t cur_exp;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (i_valid && o_ready) sbq.push_back(cur_exp);
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check($sformatf("beat_vec%0d", e.id),
                {28'd0, o_result, o_zero, o_overflow, o_underflow, o_inexact},
                {28'd0, e.res, e.fl});
        end
      end
    end
  end

  task automatic drive(input int k);
    i_valid = 1'b1;
    i_sign  = vecs[k].sign;
    i_exp   = vecs[k].exp;
    i_mant  = vecs[k].mant;
    i_lzc   = vecs[k].lzc;
    cur_exp = '{res: vecs[k].res, fl: vecs[k].fl, id: 8'(k)};
  endtask

  task automatic send(input int k);
    int t;
    drive(k);
    t = 0;
    @(negedge clk);
    while (!o_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 8'd127, 28'h4000000, 8'd1,  32'h3F800000, 4'b0000};
    vecs[1]  = '{1'b0, 8'd127, 28'h8000000, 8'd0,  32'h40000000, 4'b0000};
    vecs[2]  = '{1'b0, 8'd254, 28'h8000000, 8'd0,  32'h7F800000, 4'b0101};
    vecs[3]  = '{1'b0, 8'd127, 28'h4000004, 8'd1,  32'h3F800000, 4'b0001};
    vecs[4]  = '{1'b0, 8'd127, 28'h400000C, 8'd1,  32'h3F800002, 4'b0001};
    vecs[5]  = '{1'b0, 8'd127, 28'h7FFFFFC, 8'd1,  32'h40000000, 4'b0001};
    vecs[6]  = '{1'b1, 8'd100, 28'h0000000, 8'd28, 32'h80000000, 4'b1000};
    vecs[7]  = '{1'b0, 8'd5,   28'h0000008, 8'd24, 32'h00000000, 4'b0011};
    vecs[8]  = '{1'b1, 8'd130, 28'h6000000, 8'd1,  32'hC1400000, 4'b0000};
    vecs[9]  = '{1'b0, 8'd127, 28'h8000003, 8'd0,  32'h40000000, 4'b0001};
    vecs[10] = '{1'b0, 8'd127, 28'h800000C, 8'd0,  32'h40000001, 4'b0001};
    vecs[11] = '{1'b0, 8'd254, 28'h7FFFFFC, 8'd1,  32'h7F800000, 4'b0101};
    vecs[12] = '{1'b0, 8'd1,   28'h4000000, 8'd1,  32'h00800000, 4'b0000};
    vecs[13] = '{1'b1, 8'd1,   28'h2000000, 8'd2,  32'h80000000, 4'b0011};
    vecs[14] = '{1'b0, 8'd254, 28'h7FFFFF8, 8'd1,  32'h7F7FFFFF, 4'b0000};
    vecs[15] = '{1'b0, 8'd140, 28'h0000001, 8'd27, 32'h39000000, 4'b0000};

    i_valid = 1'b0; i_ready = 1'b1; i_sign = 1'b0;
    i_exp = '0; i_mant = '0; i_lzc = '0; cur_exp = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid",  64'(o_valid), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_flags",  64'({o_zero, o_overflow, o_underflow, o_inexact}), 64'd0);
    check("rst_ready",  64'(o_ready), 64'd1);

    // Latency: two clocks from acceptance to o_valid
    @(posedge clk); #1;
    send(0);
    i_valid = 1'b0;
    @(negedge clk); check("lat_1clk", 64'(o_valid), 64'd0);
    @(negedge clk); check("lat_2clk", 64'(o_valid), 64'd1);
    drain();

    // Full table, back to back
    for (int k = 0; k < NV; k++) send(k);
    i_valid = 1'b0;
    drain();

    // Full table again under random downstream backpressure
    fork
      begin
        for (int k = NV - 1; k >= 0; k--) send(k);
        i_valid = 1'b0;
      end
      begin
        repeat (50) begin
          @(posedge clk); #1;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_ready = 1'b1;
    drain();

    // Stall: two beats fill the pipe, third waits, output held
    i_ready = 1'b0;
    drive(3); @(posedge clk); #1;
    drive(4); @(posedge clk); #1;
    drive(7);
    @(negedge clk);
    check("bp_ready_low", 64'(o_ready), 64'd0);
    check("bp_valid",     64'(o_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("bp_hold", 64'(o_result), 64'(vecs[3].res));
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    drain();

    // Reset with both stages full
    i_ready = 1'b0;
    drive(1); @(posedge clk); #1;
    drive(2); @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk); check("t6_full", 64'(o_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_rst_valid",  64'(o_valid), 64'd0);
    check("t6_rst_result", 64'(o_result), 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    i_ready = 1'b1;
    send(8);
    i_valid = 1'b0;
    @(negedge clk); check("t6_lat_1clk", 64'(o_valid), 64'd0);
    @(negedge clk); check("t6_lat_2clk", 64'(o_valid), 64'd1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
